// File: rtl/casc_ram_pkg.sv
// casc_ram_pkg: shared definitions for the cascaded RAM.
//   state_t : controller state encoding (IDLE=0, CLEAR=1)
//   clog2   : ceiling log2, used to size the bank-select field of the address
package casc_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/casc_ram_bank.sv
// ram_bank: one WIDTH x 2^AW memory bank with synchronous write and
// synchronous read.
//   clk   : clock
//   we    : write enable, writes wdata to mem[addr] at the rising edge
//   re    : read enable, loads mem[addr] into rdata at the rising edge
//   addr  : word address inside the bank
//   wdata : write data
//   rdata : read register; holds its value while re is low
// Neither the array nor the read register is reset.
module ram_bank #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/casc_ram.sv
// casc_ram: NBANKS vertically cascaded RAM banks behind a single word
// address, with a clear controller that sweeps zeros over the whole array.
//   clk      : clock
//   rst      : asynchronous active-high reset of the control path
//   clr_req  : request to zero the whole memory (wins over we/re)
//   we, re   : write / read enables; a simultaneous write drops the read
//   a        : word address, upper bits pick the bank, lower bits the word
//   d        : write data
//   q        : read data, valid one cycle after an accepted read, held otherwise
//   q_valid  : one-cycle pulse marking new q
//   busy     : high for the 2^AW cycles of a clear sweep
//   bank_sel : one-hot of the bank touched by the last accepted access
module casc_ram
    import casc_ram_pkg::*;
#(
    parameter int  WIDTH   = 4,
    parameter int  BANK_AW = 2,
    parameter int  NBANKS  = 2,
    localparam int BSW     = clog2(NBANKS),
    localparam int AW      = BANK_AW + BSW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     a,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    output logic              q_valid,
    output logic              busy,
    output logic [NBANKS-1:0] bank_sel
);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    cnt;

    logic             wr_en;
    logic             rd_en;
    logic             access;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic [BSW-1:0]   rd_bank_p0;
    logic             q_live_p0;

    logic [NBANKS-1:0] bank_we;
    logic [NBANKS-1:0] bank_re;
    logic [WIDTH-1:0]  bank_q [NBANKS];

    // ---- controller: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- controller: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == {AW{1'b1}}) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- controller: outputs / access decode ----
    // In CLEAR the write port is owned by the sweep counter; in IDLE a
    // pending clr_req swallows any user access in the same cycle.
    always_comb begin
        busy    = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        access  = 1'b0;
        wr_addr = a;
        wr_data = d;
        if (state == CLEAR) begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = '0;
        end else if (!clr_req) begin
            wr_en  = we;
            rd_en  = re && !we;
            access = we || re;
        end
    end

    // Counter wraps back to 0 on the last sweep write, ready for next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // ---- bank array ----
    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        assign bank_we[i] = wr_en && (wr_addr[AW-1:BANK_AW] == BSW'(i));
        assign bank_re[i] = rd_en && (a[AW-1:BANK_AW] == BSW'(i));

        ram_bank #(
            .WIDTH (WIDTH),
            .AW    (BANK_AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[i]),
            .re    (bank_re[i]),
            .addr  (wr_addr[BANK_AW-1:0]),
            .wdata (wr_data),
            .rdata (bank_q[i])
        );
    end

    // ---- p0: read bookkeeping registered alongside the bank read ----
    // q is the selected bank's read register. Bank read registers only load
    // on their own read, and rd_bank_p0 only moves on a read, so q holds
    // between reads. q_live_p0 forces q to 0 until the first read after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank_p0 <= '0;
            q_live_p0  <= 1'b0;
            q_valid    <= 1'b0;
            bank_sel   <= '0;
        end else begin
            q_valid <= rd_en;
            if (rd_en) begin
                rd_bank_p0 <= a[AW-1:BANK_AW];
                q_live_p0  <= 1'b1;
            end
            if (access) begin
                bank_sel <= NBANKS'(1) << a[AW-1:BANK_AW];
            end
        end
    end

    assign q = q_live_p0 ? bank_q[rd_bank_p0] : '0;

endmodule

// File: tb/tb_casc_ram.sv
module tb_casc_ram;

    logic       clk;
    logic       rst;
    logic       clr_req;
    logic       we;
    logic       re;
    logic [2:0] a;
    logic [3:0] d;
    logic [3:0] q;
    logic       q_valid;
    logic       busy;
    logic [1:0] bank_sel;

    int total;
    int bad;

    casc_ram dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .we       (we),
        .re       (re),
        .a        (a),
        .d        (d),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .bank_sel (bank_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [3:0] data);
        a  = addr;
        d  = data;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_req = 1'b0; we = 1'b0; re = 1'b0; a = '0; d = '0;
        tick();
        tick();
        total++;
        if ({q, q_valid, busy, bank_sel} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got q=%h q_valid=%b busy=%b bank_sel=%b, need all 0",
                     q, q_valid, busy, bank_sel);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({q, q_valid, busy, bank_sel} !== 8'h00) begin
            bad++;
            $display("FAIL after_reset_idle: got q=%h q_valid=%b busy=%b bank_sel=%b, need all 0",
                     q, q_valid, busy, bank_sel);
        end
    endtask

    task automatic test_clear();
        int n;
        logic qv_seen;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        qv_seen = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            if (q_valid !== 1'b0) qv_seen = 1'b1;
            tick();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL clear_busy_len: got %0d cycles, need 8", n);
        end
        total++;
        if (qv_seen) begin
            bad++;
            $display("FAIL clear_qvalid: got q_valid=1 during clear, need 0");
        end
        for (int i = 0; i < 8; i++) begin
            a  = 3'(i);
            re = 1'b1;
            total++;
            if (q_valid !== 1'b0 && i == 0) begin
                bad++;
                $display("FAIL clear_pre_read: got q_valid=%b before first read, need 0", q_valid);
            end
            tick();
            re = 1'b0;
            total++;
            if (q_valid !== 1'b1 || q !== 4'h0) begin
                bad++;
                $display("FAIL clear_read a=%0d: got q=%h q_valid=%b, need q=0 q_valid=1",
                         i, q, q_valid);
            end
        end
        tick();
        total++;
        if (q_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_qvalid_pulse: got q_valid=%b after idle cycle, need 0", q_valid);
        end
    endtask

    task automatic test_cascade();
        logic [1:0] exp_sel;
        for (int i = 1; i < 8; i++) begin
            wr(3'(i), 4'(i - 1));
            total++;
            if (q_valid !== 1'b0) begin
                bad++;
                $display("FAIL cascade_wr_qvalid a=%0d: got %b, need 0", i, q_valid);
            end
        end
        total++;
        if (bank_sel !== 2'b10) begin
            bad++;
            $display("FAIL cascade_wr_banksel: got %b, need 10", bank_sel);
        end
        for (int i = 1; i < 8; i++) begin
            exp_sel = (i < 4) ? 2'b01 : 2'b10;
            a  = 3'(i);
            re = 1'b1;
            tick();
            re = 1'b0;
            total++;
            if (q_valid !== 1'b1 || q !== 4'(i - 1) || bank_sel !== exp_sel) begin
                bad++;
                $display("FAIL cascade_read a=%0d: got q=%h q_valid=%b bank_sel=%b, need q=%h q_valid=1 bank_sel=%b",
                         i, q, q_valid, bank_sel, 4'(i - 1), exp_sel);
            end
        end
        // idle: q holds 6 from the last read
        a = 3'd4;
        tick();
        total++;
        if (q_valid !== 1'b0 || q !== 4'h6 || bank_sel !== 2'b10) begin
            bad++;
            $display("FAIL hold_idle: got q=%h q_valid=%b bank_sel=%b, need q=6 q_valid=0 bank_sel=10",
                     q, q_valid, bank_sel);
        end
        // write to bank 0 moves bank_sel but leaves q alone
        wr(3'd0, 4'h5);
        total++;
        if (q_valid !== 1'b0 || q !== 4'h6 || bank_sel !== 2'b01) begin
            bad++;
            $display("FAIL hold_after_write: got q=%h q_valid=%b bank_sel=%b, need q=6 q_valid=0 bank_sel=01",
                     q, q_valid, bank_sel);
        end
        a = 3'd6;
        tick();
        total++;
        if (bank_sel !== 2'b01) begin
            bad++;
            $display("FAIL banksel_hold: got %b, need 01", bank_sel);
        end
    endtask

    task automatic test_collision();
        a  = 3'd5;
        d  = 4'h9;
        we = 1'b1;
        re = 1'b1;
        tick();
        we = 1'b0;
        re = 1'b0;
        total++;
        if (q_valid !== 1'b0 || q !== 4'h6 || bank_sel !== 2'b10) begin
            bad++;
            $display("FAIL collision: got q=%h q_valid=%b bank_sel=%b, need q=6 q_valid=0 bank_sel=10",
                     q, q_valid, bank_sel);
        end
        a  = 3'd5;
        re = 1'b1;
        tick();
        re = 1'b0;
        total++;
        if (q_valid !== 1'b1 || q !== 4'h9) begin
            bad++;
            $display("FAIL collision_readback: got q=%h q_valid=%b, need q=9 q_valid=1", q, q_valid);
        end
    endtask

    task automatic test_access_during_clear();
        int n;
        logic err_qv;
        logic err_sel;
        wr(3'd2, 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        err_qv = 1'b0;
        err_sel = 1'b0;
        while (busy === 1'b1 && n < 20) begin
            if (n > 0 && q_valid !== 1'b0) err_qv = 1'b1;
            if (bank_sel !== 2'b01) err_sel = 1'b1;
            if (n[0]) begin
                a = 3'd6; d = 4'h0; we = 1'b0; re = 1'b1;
            end else begin
                a = 3'd2; d = 4'hF; we = 1'b1; re = 1'b0;
            end
            clr_req = 1'b1;
            n++;
            tick();
        end
        we = 1'b0; re = 1'b0; clr_req = 1'b0;
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL clear2_busy_len: got %0d cycles, need 8", n);
        end
        total++;
        if (err_qv || err_sel) begin
            bad++;
            $display("FAIL clear2_ignore: got q_valid_err=%b bank_sel_err=%b, need 0 0", err_qv, err_sel);
        end
        a  = 3'd2;
        re = 1'b1;
        tick();
        re = 1'b0;
        total++;
        if (q_valid !== 1'b1 || q !== 4'h0) begin
            bad++;
            $display("FAIL clear2_read a=2: got q=%h q_valid=%b, need q=0 q_valid=1", q, q_valid);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [3:0] exp_q;
        for (int i = 0; i < 8; i++) wr(3'(i), 4'hF);
        a  = 3'd7;
        re = 1'b1;
        tick();
        re = 1'b0;
        total++;
        if (q !== 4'hF || bank_sel !== 2'b10) begin
            bad++;
            $display("FAIL midclr_preread: got q=%h bank_sel=%b, need q=F bank_sel=10", q, bank_sel);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || q_valid !== 1'b0 || bank_sel !== 2'b00 || q !== 4'h0) begin
            bad++;
            $display("FAIL midclr_async: got busy=%b q_valid=%b bank_sel=%b q=%h, need all 0",
                     busy, q_valid, bank_sel, q);
        end
        #1;
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midclr_stay_idle: got busy=%b, need 0", busy);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q = (i < 3) ? 4'h0 : 4'hF;
            a  = 3'(i);
            re = 1'b1;
            tick();
            re = 1'b0;
            total++;
            if (q_valid !== 1'b1 || q !== exp_q) begin
                bad++;
                $display("FAIL midclr_read a=%0d: got q=%h q_valid=%b, need q=%h q_valid=1",
                         i, q, q_valid, exp_q);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_clear();
        test_cascade();
        test_collision();
        test_access_during_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
